// File: rtl/c8b_32b.sv
// c8b_32b: byte-to-word packer with optional comma alignment.
// Bytes are packed MSB-first into 32-bit words. When alignment is enabled,
// a comma byte marks the first byte of each word.
module c8b_32b #(
    parameter logic [7:0]  COM      = 8'hBC,
    parameter int unsigned ALIGN_EN = 1
) (
    input  logic        clock4,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        aligned,
    output logic        realign_err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned PART_W = 24;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic {
        UNALIGNED = 1'b0,
        ALIGNED   = 1'b1
    } state_t;

    localparam bit     ALIGN_ON  = (ALIGN_EN != 0);
    localparam state_t RST_STATE = ALIGN_ON ? UNALIGNED : ALIGNED;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [PART_W-1:0]   part, part_nxt;
    logic [WORD_W-1:0]   data_out_nxt;
    logic                valid_out_nxt;
    logic                realign_err_nxt;
    logic                aligned_nxt;
    logic                is_com;

    assign is_com = (data_in == COM);

    // State, partial word and output registers; reset wins over any input.
    always_ff @(posedge clock4) begin
        if (reset) begin
            state       <= RST_STATE;
            idx         <= '0;
            part        <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            realign_err <= 1'b0;
            aligned     <= (RST_STATE == ALIGNED);
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            part        <= part_nxt;
            data_out    <= data_out_nxt;
            valid_out   <= valid_out_nxt;
            realign_err <= realign_err_nxt;
            aligned     <= aligned_nxt;
        end
    end

    // Next-state, byte placement, word completion and realignment decode.
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        part_nxt        = part;
        data_out_nxt    = data_out;
        valid_out_nxt   = 1'b0;
        realign_err_nxt = 1'b0;

        if (valid_in) begin
            unique case (state)
                UNALIGNED: begin
                    // Drop everything until a comma starts a word.
                    if (is_com) begin
                        state_nxt = ALIGNED;
                        part_nxt  = {COM, (PART_W - BYTE_W)'(0)};
                        idx_nxt   = IDX_W'(1);
                    end
                end
                ALIGNED: begin
                    if (ALIGN_ON && is_com && (idx != '0)) begin
                        // Comma mid-word: abandon the partial word and restart.
                        part_nxt        = {COM, (PART_W - BYTE_W)'(0)};
                        idx_nxt         = IDX_W'(1);
                        realign_err_nxt = 1'b1;
                    end else begin
                        unique case (idx)
                            2'd0: part_nxt[23:16] = data_in;
                            2'd1: part_nxt[15:8]  = data_in;
                            2'd2: part_nxt[7:0]   = data_in;
                            2'd3: begin
                                data_out_nxt  = {part, data_in};
                                valid_out_nxt = 1'b1;
                            end
                            default: ;
                        endcase
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end

        aligned_nxt = (state_nxt == ALIGNED);
    end

endmodule

// File: tb/tb_c8b_32b.sv
// Directed and random checks for the c8b_32b byte packer. Two instances share
// the input stream: one with comma alignment, one free-running.
module tb_c8b_32b;

    logic        clock4;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;

    logic [31:0] data_out,  data_out0;
    logic        valid_out, valid_out0;
    logic        aligned,   aligned0;
    logic        realign_err, realign_err0;

    int n_tot = 0;
    int n_bad = 0;

    // Per-section event counters, cleared by clr().
    int vc1, re1, vc0, re0, unal0;
    logic [31:0] w0 [0:1];

    c8b_32b #(.COM(8'hBC), .ALIGN_EN(1)) dut (
        .clock4     (clock4),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .aligned    (aligned),
        .realign_err(realign_err)
    );

    c8b_32b #(.COM(8'hBC), .ALIGN_EN(0)) dut0 (
        .clock4     (clock4),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out0),
        .valid_out  (valid_out0),
        .aligned    (aligned0),
        .realign_err(realign_err0)
    );

    initial clock4 = 1'b0;
    always #5 clock4 = ~clock4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        vc1 = 0; re1 = 0; vc0 = 0; re0 = 0; unal0 = 0;
        w0[0] = '0; w0[1] = '0;
    endtask

    // Drive one cycle on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic [7:0] b);
        @(negedge clock4);
        reset    = r;
        valid_in = v;
        data_in  = b;
        @(posedge clock4);
        #1;
        if (valid_out === 1'b1)    vc1++;
        if (realign_err === 1'b1)  re1++;
        if (valid_out0 === 1'b1) begin
            if (vc0 < 2) w0[vc0] = data_out0;
            vc0++;
        end
        if (realign_err0 === 1'b1) re0++;
        if (aligned0 !== 1'b1)     unal0++;
    endtask

    logic [7:0]  vec30 [0:7];
    logic [31:0] model_word;
    int          model_cnt;
    logic [7:0]  rb;
    logic        rv;

    initial begin
        reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;
        clr();

        // Reset state of both instances.
        step(1'b1, 1'b1, 8'hBC);
        chk("rst_dout",   data_out, 32'h0);
        chk("rst_vout",   32'(valid_out), 32'h0);
        chk("rst_align",  32'(aligned), 32'h0);
        chk("rst_rerr",   32'(realign_err), 32'h0);
        chk("rst_align0", 32'(aligned0), 32'h1);
        chk("rst_dout0",  data_out0, 32'h0);

        // Free-running packing from reset, commas are plain data.
        vec30[0] = 8'h12; vec30[1] = 8'h34; vec30[2] = 8'h56; vec30[3] = 8'h78;
        vec30[4] = 8'h9A; vec30[5] = 8'hBC; vec30[6] = 8'hDE; vec30[7] = 8'hF0;
        clr();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, vec30[i]);
            if (i == 3) begin
                chk("na_w1_vout", 32'(valid_out0), 32'h1);
                chk("na_w1_dout", data_out0, 32'h12345678);
            end
        end
        chk("na_vcount", 32'(vc0), 32'd2);
        chk("na_word0",  w0[0], 32'h12345678);
        chk("na_word1",  w0[1], 32'h9ABCDEF0);
        chk("na_unal",   32'(unal0), 32'd0);
        chk("na_rerr",   32'(re0), 32'd0);

        // Comma alignment: leading junk dropped, word starts at the comma.
        step(1'b1, 1'b0, 8'h00);
        clr();
        step(1'b0, 1'b1, 8'h11);
        chk("al_drop_align", 32'(aligned), 32'h0);
        step(1'b0, 1'b1, 8'hBC);
        chk("al_com_align", 32'(aligned), 32'h1);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'h33);
        chk("al_early_vc", 32'(vc1), 32'd0);
        step(1'b0, 1'b1, 8'h44);
        chk("al_vout", 32'(valid_out), 32'h1);
        chk("al_dout", data_out, 32'hBC223344);
        step(1'b0, 1'b0, 8'h55);
        chk("al_vout_pulse", 32'(valid_out), 32'h0);
        chk("al_dout_hold",  data_out, 32'hBC223344);

        // Gaps inside a word do not advance or complete it.
        clr();
        step(1'b0, 1'b1, 8'hA1);
        step(1'b0, 1'b0, 8'hB2);
        chk("gap1_vout", 32'(valid_out), 32'h0);
        step(1'b0, 1'b0, 8'hC3);
        chk("gap2_vout", 32'(valid_out), 32'h0);
        step(1'b0, 1'b1, 8'hB2);
        step(1'b0, 1'b1, 8'hC3);
        chk("gap_pre_vc", 32'(vc1), 32'd0);
        step(1'b0, 1'b1, 8'hD4);
        chk("gap_vc",   32'(vc1), 32'd1);
        chk("gap_dout", data_out, 32'hA1B2C3D4);

        // Comma mid-word realigns and flags an error.
        clr();
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'hBC);
        chk("ra_rerr", 32'(realign_err), 32'h1);
        chk("ra_vout", 32'(valid_out), 32'h0);
        step(1'b0, 1'b1, 8'h05);
        chk("ra_rerr_pulse", 32'(realign_err), 32'h0);
        step(1'b0, 1'b1, 8'h06);
        step(1'b0, 1'b1, 8'h07);
        chk("ra_vc",   32'(vc1), 32'd1);
        chk("ra_dout", data_out, 32'hBC050607);
        chk("ra_recount", 32'(re1), 32'd1);

        // Reset mid-word discards the partial word and the reset-cycle byte.
        clr();
        step(1'b0, 1'b1, 8'hBC);
        step(1'b0, 1'b1, 8'hAA);
        step(1'b1, 1'b1, 8'hBC);
        chk("mr_align", 32'(aligned), 32'h0);
        chk("mr_dout",  data_out, 32'h0);
        step(1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'h66);
        step(1'b0, 1'b1, 8'h77);
        step(1'b0, 1'b1, 8'h88);
        chk("mr_vc",    32'(vc1), 32'd0);
        chk("mr_align2", 32'(aligned), 32'h0);
        chk("mr_dout2", data_out, 32'h0);

        // Random comma-free stream after an initial comma, against a reference packer.
        step(1'b1, 1'b0, 8'h00);
        clr();
        step(1'b0, 1'b1, 8'hBC);
        model_word = 32'h000000BC;
        model_cnt  = 1;
        for (int i = 0; i < 1000; i++) begin
            rv = ($urandom_range(0, 9) < 7);
            rb = 8'($urandom_range(0, 255));
            if (rb == 8'hBC) rb = 8'hBD;
            step(1'b0, rv, rb);
            if (rv) begin
                model_word = {model_word[23:0], rb};
                model_cnt++;
            end
            if (rv && (model_cnt % 4 == 0)) begin
                chk("rnd_vout", 32'(valid_out), 32'h1);
                chk("rnd_dout", data_out, model_word);
            end else begin
                chk("rnd_idle", 32'(valid_out), 32'h0);
            end
        end
        chk("rnd_vcount", 32'(vc1), 32'(model_cnt / 4));
        chk("rnd_rerr",   32'(re1), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/c8b_32b.md
C8B_32B -- requirements
Module: c8b_32b

Interface
REQ-001 SHALL provide parameter COM, default 8'hBC, the alignment (comma) byte value.
REQ-002 SHALL provide parameter ALIGN_EN, default 1; 1 = comma alignment enabled, 0 = free-running packing from reset.
REQ-003 SHALL provide port clock4  input  1  byte clock; all state changes on its rising edge; the only clock.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset, sampled on clock4.
REQ-005 SHALL provide port data_in  input  8  byte lane.
REQ-006 SHALL provide port valid_in  input  1  data_in qualifier.
REQ-007 SHALL provide port data_out  output  32  assembled word, registered.
REQ-008 SHALL provide port valid_out  output  1  one-cycle pulse marking a new data_out.
REQ-009 SHALL provide port aligned  output  1  high while in state ALIGNED.
REQ-010 SHALL provide port realign_err  output  1  one-cycle pulse on comma received mid-word.

Function
REQ-011 SHALL pack bytes MSB-first: 1st accepted byte -> data_out[31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-012 SHALL accept a byte only in cycles with valid_in=1; cycles with valid_in=0 leave the byte index, partial word and state unchanged.
REQ-013 SHALL keep a 2-bit byte index 0..3, incremented per accepted byte in ALIGNED, wrapping 3 -> 0.
REQ-014 SHALL, on acceptance of byte index 3, load the full word into data_out and assert valid_out for exactly the next cycle (latency: data_out/valid_out update on the clock4 edge sampling the 4th byte).
REQ-015 SHALL hold data_out unchanged between words; valid_out=0 in all other cycles.
REQ-016 SHALL implement states UNALIGNED and ALIGNED.
REQ-017 SHALL, in UNALIGNED, discard every accepted byte not equal to COM, producing no valid_out.
REQ-018 SHALL, in UNALIGNED, on an accepted byte equal to COM, move to ALIGNED, store COM as byte index 0 ([31:24]), and set the index to 1.
REQ-019 SHALL, in ALIGNED, treat an accepted COM at index 0 as ordinary data.
REQ-020 SHALL, in ALIGNED, on an accepted COM at index 1, 2 or 3, discard the partial word, store COM as byte index 0, set the index to 1, pulse realign_err for one cycle, and emit no valid_out for the discarded word.
REQ-021 SHALL, with ALIGN_EN=0, remain permanently in ALIGNED, never pulse realign_err, and treat COM as ordinary data.
REQ-022 SHALL, when valid_in=0 in the cycle a word would complete, not complete the word (completion requires an accepted 4th byte).
REQ-023 SHALL drive aligned=1 exactly while the state is ALIGNED.

Reset
REQ-024 SHALL, while reset=1 at a clock4 edge, set data_out=32'h0, valid_out=0, realign_err=0, byte index=0 and partial word=0, and set the state to UNALIGNED (ALIGN_EN=1) or ALIGNED (ALIGN_EN=0).
REQ-025 SHALL give reset priority over all inputs, including a byte presented in the reset cycle, which is discarded.
REQ-026 SHALL, on reset mid-word, discard the partial word without asserting valid_out.

Verification
REQ-027 SHALL cover: ALIGN_EN=1, bytes 11,BC,22,33,44 all valid -> 11 dropped; aligned=1 after BC; one valid_out with data_out=32'hBC223344.
REQ-028 SHALL cover: aligned, bytes A1,(valid_in=0 x2),B2,C3,D4 -> single valid_out, data_out=32'hA1B2C3D4, no pulse during the gaps.
REQ-029 SHALL cover: aligned, bytes 01,02,BC,05,06,07 -> realign_err pulse at BC; no word 0102xxxx; next valid_out data_out=32'hBC050607.
REQ-030 SHALL cover: ALIGN_EN=0, bytes 12,34,56,78,9A,BC,DE,F0 from reset -> valid_out twice, 32'h12345678 then 32'h9ABCDEF0, aligned=1 throughout, realign_err never set.
REQ-031 SHALL cover: aligned, bytes BC,AA, then reset=1 one cycle, then 55,66,77,88 -> no valid_out; aligned=0 after reset (ALIGN_EN=1), data_out=0; bytes 55..88 discarded.
REQ-032 SHALL cover: 1000 random valid/gap byte streams, comma-free after the initial BC, against a reference packer -> every word matches in order, valid_out count = accepted bytes/4.
